fnd_scan_driver: RTL and testbench
==================================

Name: fnd_scan_driver

Overview:
- Time-multiplexed driver for a 4-digit common-anode seven-segment (FND) display.
- Combines a digit-select decoder (2-bit scan index to active-low one-hot digit enable) and a BCD/hex-to-FND font decoder (4-bit value to active-low segment pattern).
- A prescaled scan counter drives both decoders.
- Sits between the calculator datapath, which supplies four 4-bit digit values, and the board FND pins.

Parameters:
- CLK_FREQ, 100_000_000, i_clk frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. Prescaler terminal count is CLK_FREQ/SCAN_HZ - 1, which must be at least 1.

Ports:
- i_clk  input  1  system clock; all state updates on its rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_en  input  1  display enable, active-high. 0 blanks all digits and segments.
- i_value  input  16  four digit values: [3:0] digit0 (rightmost) … [15:12] digit3 (leftmost).
- i_dp  input  4  decimal point request per digit, active-high; bit k belongs to digit k.
- i_lzb  input  1  leading-zero blanking enable, active-high.
- o_digit  output  4  digit anode enables, active-low one-hot; bit k drives digit k.
- o_font  output  8  segment cathodes, active-low, bit order {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset (asynchronous, i_reset=1): prescaler=0, scan index=0, o_digit=4'b1111, o_font=8'hFF. Reset held mid-scan forces these values immediately. Scanning restarts from index 0 after release.
- Prescaler:
  - Counts every cycle from 0 up to CLK_FREQ/SCAN_HZ-1, then wraps to 0 and produces a one-cycle tick.
  - It runs regardless of i_en.
- Scan index:
  - 2-bit counter that increments on tick and wraps 3→0.
  - Sequence is 0,1,2,3,0…
- Digit-select decode, for index with i_en=1:
  - 00→1110, 01→1101, 10→1011, 11→0111.
  - i_en=0 → 1111 for any index.
- Font decode, active-low, dp bit = 1 unless requested:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - All 16 codes are legal and there is no invalid-code case.
- Decimal point: if i_dp[index]=1, bit7 of o_font is cleared. Applies only to non-blanked digits.
- Selected value: i_value nibble [4*index+3 : 4*index].
- Leading-zero blanking (i_lzb=1):
  - Digit k (k≥1) is blanked when its nibble and all higher nibbles are 0.
  - Digit0 is never blanked, so 0000 shows "0" on digit0 only.
  - A blanked digit outputs o_font=8'hFF; o_digit still follows the scan.
- Enable: i_en=0 → o_digit=4'b1111 and o_font=8'hFF. Prescaler and scan index continue counting.
- Output timing: o_digit and o_font are registered. They reflect the scan index, i_value, i_dp, i_lzb and i_en sampled one clock earlier, so latency is exactly 1 cycle. o_digit and o_font always update on the same edge, so no ghost digit appears.
- Inputs are sampled directly with no internal latch. Changes to i_value take effect on the next clock for the currently scanned digit.

Test Plan:
- Reset/enable:
  - Drive CLK_FREQ=40, SCAN_HZ=10, i_reset=1, any inputs → o_digit=1111, o_font=FF.
  - Release with i_en=1, i_value=16'h0000, i_lzb=0 → o_digit steps 1110,1101,1011,0111,1110 every 4 cycles, with o_font=C0 throughout.
- Font sweep:
  - Hold scan on digit0 and apply i_value[3:0]=0…F → o_font follows the table: 0→C0, 5→92, A→88, F→8E, 2→A4, 3→B0, 4→99, 8→80.
- Digit mapping:
  - i_value=16'h1234, i_dp=4'b0100 → index0 gives digit 1110 with font 99 (4).
  - Index1 gives 1101/B0 (3); index2 gives 1011/24 (2 plus dp); index3 gives 0111/F9 (1).
- Disable:
  - i_en=0 mid-scan with i_value=16'h5A5A → next cycle o_digit=1111 and o_font=FF.
  - Re-enable → display resumes at the current scan index with no reset of the counter.
- Leading-zero blanking:
  - i_lzb=1, i_value=16'h0070 → digit3 and digit2 give FF, digit1 gives F8, digit0 gives C0.
  - i_value=16'h0000 → only digit0 shows C0.
- Async reset mid-operation:
  - Assert i_reset between clock edges during index 2 → outputs go to 1111/FF without a clock edge.
  - After release, the first displayed digit is index0.

Source files
------------

// File: rtl/fnd_scan_driver.sv
// Four-digit common-anode seven-segment scan driver: prescaled digit scan, font decode, leading-zero blanking.
// Outputs are registered, 1-cycle latency from sampled inputs; no handshake, inputs sampled every cycle.
module fnd_scan_driver #(
   parameter int CLK_FREQ = 100_000_000,
   parameter int SCAN_HZ  = 1000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_en,
   input  logic [15:0] i_value,
   input  logic [3:0]  i_dp,
   input  logic        i_lzb,
   output logic [3:0]  o_digit,
   output logic [7:0]  o_font
);

   localparam int TC = CLK_FREQ / SCAN_HZ - 1;
   localparam int CW = (TC < 1) ? 1 : $clog2(TC + 1);
   localparam logic [CW-1:0] TC_C = CW'(TC);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [3:0]    digit_q, digit_d;
   logic [7:0]    font_q, font_d;
   logic          tick;
   logic [3:0]    nib;
   logic [3:0]    nib_zero;
   logic [3:0]    blank;

   function automatic logic [7:0] font_lut(input logic [3:0] v);
      logic [7:0] f;
      case (v)
         4'h0: f = 8'hC0;
         4'h1: f = 8'hF9;
         4'h2: f = 8'hA4;
         4'h3: f = 8'hB0;
         4'h4: f = 8'h99;
         4'h5: f = 8'h92;
         4'h6: f = 8'h82;
         4'h7: f = 8'hF8;
         4'h8: f = 8'h80;
         4'h9: f = 8'h90;
         4'hA: f = 8'h88;
         4'hB: f = 8'h83;
         4'hC: f = 8'hC6;
         4'hD: f = 8'hA1;
         4'hE: f = 8'h86;
         default: f = 8'h8E;
      endcase
      return f;
   endfunction

   // Prescaler free-runs regardless of i_en so re-enabling resumes mid-scan.
   always_comb begin
      tick  = (cnt_q == TC_C);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      idx_d = tick ? idx_q + 2'd1 : idx_q;
   end

   // A digit is blank when it and every digit to its left hold zero; digit0 always shows.
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         nib_zero[k] = (i_value[4*k +: 4] == 4'h0);
      end
      blank[3] = nib_zero[3];
      blank[2] = nib_zero[3] & nib_zero[2];
      blank[1] = nib_zero[3] & nib_zero[2] & nib_zero[1];
      blank[0] = 1'b0;
   end

   always_comb begin
      digit_d = 4'b1111;
      font_d  = 8'hFF;
      nib     = i_value[{idx_q, 2'b00} +: 4];
      if (i_en) begin
         digit_d = ~(4'b0001 << idx_q);
         if (!(i_lzb && blank[idx_q])) begin
            font_d = font_lut(nib);
            if (i_dp[idx_q]) begin
               font_d[7] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         cnt_q   <= '0;
         idx_q   <= 2'd0;
         digit_q <= 4'b1111;
         font_q  <= 8'hFF;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         font_q  <= font_d;
      end
   end

   assign o_digit = digit_q;
   assign o_font  = font_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver with a 4-cycle scan period (CLK_FREQ=40, SCAN_HZ=10).
module tb_fnd_scan_driver;

   logic        i_clk;
   logic        i_reset;
   logic        i_en;
   logic [15:0] i_value;
   logic [3:0]  i_dp;
   logic        i_lzb;
   logic [3:0]  o_digit;
   logic [7:0]  o_font;

   int n_chk = 0;
   int n_err = 0;

   localparam logic [3:0] DIG [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [7:0] MAP_1234 [4] = '{8'h99, 8'hB0, 8'h24, 8'hF9};
   localparam logic [7:0] LZB_0070 [4] = '{8'hC0, 8'hF8, 8'hFF, 8'hFF};
   localparam logic [7:0] LZB_0000 [4] = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
   localparam logic [3:0] SWP_V [8] = '{4'h0, 4'h5, 4'hA, 4'hF, 4'h2, 4'h3, 4'h4, 4'h8};
   localparam logic [7:0] SWP_F [8] = '{8'hC0, 8'h92, 8'h88, 8'h8E, 8'hA4, 8'hB0, 8'h99, 8'h80};

   fnd_scan_driver #(
      .CLK_FREQ(40),
      .SCAN_HZ (10)
   ) dut (
      .i_clk  (i_clk),
      .i_reset(i_reset),
      .i_en   (i_en),
      .i_value(i_value),
      .i_dp   (i_dp),
      .i_lzb  (i_lzb),
      .o_digit(o_digit),
      .o_font (o_font)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [3:0] ed, input logic [7:0] ef);
      chk_eq({tag, "_dig"}, {4'h0, o_digit}, {4'h0, ed});
      chk_eq({tag, "_fnt"}, o_font, ef);
   endtask

   // One clock; outputs sampled on the following falling edge.
   task automatic step(input string tag, input logic [3:0] ed, input logic [7:0] ef);
      @(posedge i_clk);
      @(negedge i_clk);
      chk_out(tag, ed, ef);
   endtask

   // Leaves the bench at a falling edge with reset released; next rising edge samples index 0.
   task automatic do_reset();
      @(negedge i_clk);
      i_reset = 1'b1;
      #1 chk_out("rst_async", 4'b1111, 8'hFF);
      @(posedge i_clk);
      #1 chk_out("rst_held", 4'b1111, 8'hFF);
      @(negedge i_clk);
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset = 1'b1;
      i_en    = 1'b1;
      i_value = 16'hFFFF;
      i_dp    = 4'hF;
      i_lzb   = 1'b0;

      // Reset state and basic scan sequence.
      do_reset();
      i_value = 16'h0000;
      i_dp    = 4'h0;
      for (int n = 1; n <= 20; n++) begin
         step("scan", DIG[((n - 1) / 4) % 4], 8'hC0);
      end

      // Font sweep while index 0 is scanned.
      for (int i = 0; i < 8; i++) begin
         if (i % 4 == 0) do_reset();
         i_value = {12'h000, SWP_V[i]};
         step("font", DIG[0], SWP_F[i]);
      end

      // Digit mapping and decimal point.
      do_reset();
      i_value = 16'h1234;
      i_dp    = 4'b0100;
      for (int n = 1; n <= 16; n++) begin
         step("map", DIG[(n - 1) / 4], MAP_1234[(n - 1) / 4]);
      end

      // Disable mid-scan; re-enable resumes at the running index.
      do_reset();
      i_value = 16'h5A5A;
      i_dp    = 4'h0;
      for (int n = 1; n <= 4; n++) step("dis_pre", DIG[0], 8'h88);
      step("dis_pre", DIG[1], 8'h92);
      i_en = 1'b0;
      for (int n = 6; n <= 8; n++) step("dis_off", 4'b1111, 8'hFF);
      i_en = 1'b1;
      step("dis_resume", DIG[2], 8'h88);

      // Leading-zero blanking.
      do_reset();
      i_lzb   = 1'b1;
      i_value = 16'h0070;
      for (int n = 1; n <= 16; n++) begin
         step("lzb70", DIG[(n - 1) / 4], LZB_0070[(n - 1) / 4]);
      end
      do_reset();
      i_value = 16'h0000;
      for (int n = 1; n <= 16; n++) begin
         step("lzb00", DIG[(n - 1) / 4], LZB_0000[(n - 1) / 4]);
      end
      i_lzb = 1'b0;

      // Asynchronous reset between edges while index 2 is displayed.
      do_reset();
      i_value = 16'h1234;
      for (int n = 1; n <= 9; n++) step("ar_pre", DIG[(n - 1) / 4], MAP_1234[(n - 1) / 4] | 8'h80);
      @(posedge i_clk);
      #2 i_reset = 1'b1;
      #1 chk_out("ar_async", 4'b1111, 8'hFF);
      @(negedge i_clk);
      i_reset = 1'b0;
      for (int n = 1; n <= 4; n++) step("ar_post", DIG[0], 8'h99);
      step("ar_post", DIG[1], 8'hB0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
